// File: rtl/task_14_rev.sv
// Frame-reversal stage: captures i_first..i_last frames into two ping-pong banks and
// replays each frame's beats in reverse order. Optional drop pulse o_err with TASK_REV_ERR_EN.
module task_14_rev #(
    parameter int TASK_INPUT_WIDTH  = 8,
    parameter int TASK_OUTPUT_WIDTH = 8,
    parameter int MAX_FRAME_LEN     = 16,
    parameter int INPUT_STREAMS     = 1,
    parameter int OUTPUT_STREAMS    = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic                         i_first,
    input  logic                         i_last,
    input  logic [TASK_INPUT_WIDTH-1:0]  i_data,
    output logic                         o_valid,
    output logic                         o_last,
    output logic [TASK_OUTPUT_WIDTH-1:0] o_data
`ifdef TASK_REV_ERR_EN
    ,
    output logic                         o_err
`endif
);

    // state     | meaning
    // W_IDLE    | waiting for i_first
    // W_FILL    | capturing beats into bank wr_ptr
    // W_DROP    | discarding beats of a dropped frame until i_last
    // R_IDLE    | no readout in progress; a READY bank is emitted from immediately
    // R_OUT     | emitting bank rd_ptr from raddr down to 0

    localparam int AW    = $clog2(MAX_FRAME_LEN + 1);
    localparam int DEPTH = 2 ** (AW + 1);
    localparam logic [AW-1:0] MAX_CNT = AW'(MAX_FRAME_LEN);
    localparam logic [AW-1:0] ONE     = AW'(1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_READY, B_READING} bank_t;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_t;
    typedef enum logic {R_IDLE, R_OUT} rd_t;

    bank_t           bank_q [2];
    bank_t           bank_d [2];
    logic [AW-1:0]   len_q  [2];
    logic [AW-1:0]   len_d  [2];
    wr_t             w_q, w_d;
    rd_t             r_q, r_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   raddr_q, raddr_d;

    logic                         we;
    logic [AW-1:0]                w_addr;
    logic                         drop;
    logic                         emit;
    logic [AW-1:0]                e_addr;
    logic                         ov_d, ol_d;
    logic [TASK_OUTPUT_WIDTH-1:0] od_d;

    logic [TASK_INPUT_WIDTH-1:0] mem [DEPTH];

    logic unused_cfg;
    assign unused_cfg = ^{INPUT_STREAMS, OUTPUT_STREAMS};

    always_comb begin
        w_d      = w_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        len_d    = len_q;
        we       = 1'b0;
        w_addr   = cnt_q;
        drop     = 1'b0;

        if (i_valid) begin
            if (i_first) begin
                // Abort frees the bank, but the new start still sees it as FILLING.
                if (w_q == W_FILL) begin
                    bank_d[wr_ptr_q] = B_EMPTY;
                    drop             = 1'b1;
                end
                if (bank_q[wr_ptr_q] == B_EMPTY) begin
                    we               = 1'b1;
                    w_addr           = '0;
                    cnt_d            = ONE;
                    bank_d[wr_ptr_q] = B_FILLING;
                    if (i_last) begin
                        bank_d[wr_ptr_q] = B_READY;
                        len_d[wr_ptr_q]  = ONE;
                        wr_ptr_d         = ~wr_ptr_q;
                        w_d              = W_IDLE;
                    end else begin
                        w_d = W_FILL;
                    end
                end else begin
                    drop = 1'b1;
                    w_d  = i_last ? W_IDLE : W_DROP;
                end
            end else begin
                case (w_q)
                    W_FILL: begin
                        if (cnt_q == MAX_CNT) begin
                            bank_d[wr_ptr_q] = B_EMPTY;
                            drop             = 1'b1;
                            w_d              = i_last ? W_IDLE : W_DROP;
                        end else begin
                            we    = 1'b1;
                            cnt_d = cnt_q + ONE;
                            if (i_last) begin
                                bank_d[wr_ptr_q] = B_READY;
                                len_d[wr_ptr_q]  = cnt_q + ONE;
                                wr_ptr_d         = ~wr_ptr_q;
                                w_d              = W_IDLE;
                            end
                        end
                    end
                    W_DROP: begin
                        if (i_last) w_d = W_IDLE;
                    end
                    default: ;
                endcase
            end
        end

        // Reader only touches READY/READING banks, so it never collides with the writer.
        r_d      = r_q;
        rd_ptr_d = rd_ptr_q;
        raddr_d  = raddr_q;
        emit     = 1'b0;
        e_addr   = raddr_q;
        if (r_q == R_OUT) begin
            emit = 1'b1;
        end else if (bank_q[rd_ptr_q] == B_READY) begin
            emit   = 1'b1;
            e_addr = len_q[rd_ptr_q] - ONE;
        end

        if (emit) begin
            if (e_addr == '0) begin
                bank_d[rd_ptr_q] = B_EMPTY;
                rd_ptr_d         = ~rd_ptr_q;
                r_d              = R_IDLE;
            end else begin
                bank_d[rd_ptr_q] = B_READING;
                raddr_d          = e_addr - ONE;
                r_d              = R_OUT;
            end
        end

        ov_d = emit;
        ol_d = emit && (e_addr == '0);
        od_d = emit ? mem[{rd_ptr_q, e_addr}] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (we) mem[{wr_ptr_q, w_addr}] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bank_q[0] <= B_EMPTY;
            bank_q[1] <= B_EMPTY;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            w_q       <= W_IDLE;
            r_q       <= R_IDLE;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            raddr_q   <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_data    <= '0;
        end else begin
            bank_q   <= bank_d;
            len_q    <= len_d;
            w_q      <= w_d;
            r_q      <= r_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            raddr_q  <= raddr_d;
            o_valid  <= ov_d;
            o_last   <= ol_d;
            o_data   <= od_d;
        end
    end

`ifdef TASK_REV_ERR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_err <= 1'b0;
        else          o_err <= drop;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_task_14_rev.sv
// Bench for task_14_rev: directed frames plus random traffic against a frame-level
// reference model that schedules reversed beats and bank release times arithmetically.
module tb_task_14_rev;
    localparam int W    = 8;
    localparam int MAXL = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid, i_first, i_last;
    logic [W-1:0] i_data;
    logic         o_valid, o_last;
    logic [W-1:0] o_data;
`ifdef TASK_REV_ERR_EN
    logic         o_err;
`endif

    task_14_rev #(
        .TASK_INPUT_WIDTH (W),
        .TASK_OUTPUT_WIDTH(W),
        .MAX_FRAME_LEN    (MAXL),
        .INPUT_STREAMS    (1),
        .OUTPUT_STREAMS   (1)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(i_valid),
        .i_first(i_first),
        .i_last (i_last),
        .i_data (i_data),
        .o_valid(o_valid),
        .o_last (o_last),
        .o_data (o_data)
`ifdef TASK_REV_ERR_EN
        ,
        .o_err  (o_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: one frame buffer, per-bank "busy" and release edge, and
    // the edge at which the last scheduled readout ends.
    logic [7:0] fq[$];
    bit         collecting, skipping;
    int         wb;
    bit         filling[2];
    int         free_at[2];
    int         last_end;
    int         exp_d[int];
    bit         exp_l[int];
    bit         exp_e[int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        collecting = 1'b0;
        skipping   = 1'b0;
        wb         = 0;
        filling[0] = 1'b0;
        filling[1] = 1'b0;
        free_at[0] = -1;
        free_at[1] = -1;
        last_end   = -1;
        exp_d.delete();
        exp_l.delete();
        exp_e.delete();
    endtask

    task automatic commit(input int t);
        int len, start;
        len   = fq.size();
        start = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
        for (int i = 0; i < len; i++) begin
            exp_d[start + i] = int'(fq[len - 1 - i]);
            exp_l[start + i] = (i == len - 1);
        end
        last_end    = start + len - 1;
        free_at[wb] = last_end;
        filling[wb] = 1'b0;
        wb          = 1 - wb;
        collecting  = 1'b0;
    endtask

    task automatic drop_frame(input int t, input bit l);
        exp_e[t]   = 1'b1;
        collecting = 1'b0;
        skipping   = !l;
    endtask

    task automatic model_edge(input int t, input bit v, input bit f, input bit l, input logic [7:0] d);
        if (!v) return;
        if (f) begin
            if (collecting) begin
                filling[wb] = 1'b0;
                free_at[wb] = t;
                exp_e[t]    = 1'b1;
                collecting  = 1'b0;
            end
            skipping = 1'b0;
            if (!filling[wb] && free_at[wb] < t) begin
                fq.delete();
                fq.push_back(d);
                filling[wb] = 1'b1;
                collecting  = 1'b1;
                if (l) commit(t);
            end else begin
                drop_frame(t, l);
            end
        end else if (collecting) begin
            if (fq.size() == MAXL) begin
                filling[wb] = 1'b0;
                free_at[wb] = t;
                drop_frame(t, l);
            end else begin
                fq.push_back(d);
                if (l) commit(t);
            end
        end else if (skipping && l) begin
            skipping = 1'b0;
        end
    endtask

    task automatic check_out();
        bit ev;
        ev = exp_d.exists(cyc);
        chk("valid", 32'(o_valid), 32'(ev));
        if (ev) begin
            chk("data", 32'(o_data), 32'(exp_d[cyc]));
            chk("last", 32'(o_last), 32'(exp_l[cyc]));
        end else begin
            chk("last_idle", 32'(o_last), 32'd0);
        end
`ifdef TASK_REV_ERR_EN
        chk("err", 32'(o_err), 32'(exp_e.exists(cyc)));
`endif
    endtask

    task automatic step(input bit v, input bit f, input bit l, input logic [7:0] d);
        i_valid = v;
        i_first = f;
        i_last  = l;
        i_data  = d;
        model_edge(cyc + 1, v, f, l, d);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++)
            step(1'b1, i == 0, i == len - 1, base + 8'(i));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_last"},  32'(o_last),  32'd0);
        chk({tag, "_data"},  32'(o_data),  32'd0);
`ifdef TASK_REV_ERR_EN
        chk({tag, "_err"},   32'(o_err),   32'd0);
`endif
    endtask

    int         gap, len;
    bit         sv, f;

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        cyc = 3;
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic 3-beat frame, then a single-beat frame.
        send_frame(3, 8'h01);
        idle(5);
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        idle(4);

        // Three back-to-back 4-beat frames.
        send_frame(4, 8'h60);
        send_frame(4, 8'h70);
        send_frame(4, 8'h80);
        idle(16);

        // Overflowing frame followed by a short frame.
        send_frame(MAXL + 1, 8'h30);
        send_frame(2, 8'h10);
        idle(6);

        // Abort by i_first at beat 3, then a 2-beat frame.
        step(1'b1, 1'b1, 1'b0, 8'h40);
        step(1'b1, 1'b0, 1'b0, 8'h41);
        step(1'b1, 1'b1, 1'b0, 8'h42);
        send_frame(2, 8'h20);
        idle(6);

        // Reset in the middle of an 8-beat readout.
        send_frame(8, 8'hC0);
        idle(3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        send_frame(5, 8'hD0);
        idle(8);

        // Random traffic: gaps, stray beats, long/overflowing frames, mid-frame restarts.
        for (int k = 0; k < 90; k++) begin
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) gap = 0;
            for (int g = 0; g < gap; g++) begin
                sv = ($urandom_range(0, 5) == 0);
                step(sv, sv ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            end
            if ($urandom_range(0, 6) == 0) len = $urandom_range(MAXL - 1, MAXL + 2);
            else                          len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                f = (i == 0) || ($urandom_range(0, 29) == 0);
                step(1'b1, f, i == len - 1, 8'($urandom));
            end
        end
        idle(2 * MAXL + 8);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
